// File: rtl/score_bcd.sv
// Score and high-score keeper for the snake game. Once per frame it snapshots both
// values and converts the score to packed BCD with a 12-step double-dabble engine.
module score_bcd #(
  parameter int POINTS    = 1,
  parameter int MAX_SCORE = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        eat,
  input  logic        game_over,
  input  logic        frame,
  output logic [11:0] score,
  output logic [11:0] hiscore,
  output logic [11:0] disp_score,
  output logic [11:0] disp_hi,
  output logic [15:0] bcd,
  output logic        bcd_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [12:0] POINTS_W = 13'(POINTS);
  localparam logic [12:0] MAX_W    = 13'(MAX_SCORE);

  logic        playing_q, playing_d;
  logic [11:0] score_q, score_d;
  logic [11:0] hiscore_q, hiscore_d;
  logic [12:0] sum;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [27:0] sh_q, sh_d;
  logic [11:0] disp_score_q, disp_score_d;
  logic [11:0] disp_hi_q, disp_hi_d;
  logic [15:0] bcd_q, bcd_d;
  logic        bcd_valid_q, bcd_valid_d;
  logic        busy_q, busy_d;

  // One double-dabble iteration: correct every BCD digit >= 5, then shift left.
  function automatic logic [27:0] dabble_step(input logic [27:0] s);
    logic [15:0] d;
    d = s[27:12];
    for (int n = 0; n < 4; n++) begin
      if (d[4*n +: 4] >= 4'd5) begin
        d[4*n +: 4] = d[4*n +: 4] + 4'd3;
      end
    end
    return {d, s[11:0]} << 1;
  endfunction

  // new_game wins over everything; game_over wins over eat, so a same-cycle eat is lost.
  always_comb begin
    playing_d = playing_q;
    score_d   = score_q;
    hiscore_d = hiscore_q;
    sum       = {1'b0, score_q} + POINTS_W;
    if (new_game) begin
      score_d   = '0;
      playing_d = 1'b1;
    end else if (playing_q && game_over) begin
      playing_d = 1'b0;
      if (score_q > hiscore_q) begin
        hiscore_d = score_q;
      end
    end else if (playing_q && eat) begin
      score_d = (sum > MAX_W) ? MAX_W[11:0] : sum[11:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    disp_score_d = disp_score_q;
    disp_hi_d    = disp_hi_q;
    bcd_d        = bcd_q;
    bcd_valid_d  = bcd_valid_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (frame) begin
          disp_score_d = score_q;
          disp_hi_d    = hiscore_q;
          sh_d         = {16'b0, score_q};
          cnt_d        = '0;
          bcd_valid_d  = 1'b0;
          busy_d       = 1'b1;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        sh_d  = dabble_step(sh_q);
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd11) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d       = sh_q[27:12];
        bcd_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      playing_q    <= 1'b0;
      score_q      <= '0;
      hiscore_q    <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      disp_score_q <= '0;
      disp_hi_q    <= '0;
      bcd_q        <= '0;
      bcd_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      playing_q    <= playing_d;
      score_q      <= score_d;
      hiscore_q    <= hiscore_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      disp_score_q <= disp_score_d;
      disp_hi_q    <= disp_hi_d;
      bcd_q        <= bcd_d;
      bcd_valid_q  <= bcd_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign score      = score_q;
  assign hiscore    = hiscore_q;
  assign disp_score = disp_score_q;
  assign disp_hi    = disp_hi_q;
  assign bcd        = bcd_q;
  assign bcd_valid  = bcd_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_score_bcd.sv
// Bench for score_bcd: three instances (POINTS 617, 1000, default 1) share one stimulus
// stream and are compared every cycle against an arithmetic reference model.
module tb_score_bcd;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic new_game = 1'b0;
  logic eat = 1'b0;
  logic game_over = 1'b0;
  logic frame = 1'b0;

  logic [11:0] score_o      [3];
  logic [11:0] hiscore_o    [3];
  logic [11:0] disp_score_o [3];
  logic [11:0] disp_hi_o    [3];
  logic [15:0] bcd_o        [3];
  logic        bcd_valid_o  [3];
  logic        busy_o       [3];

  int checks = 0;
  int errors = 0;

  int pts [3] = '{617, 1000, 1};
  int m_score [3];
  int m_hi    [3];
  int m_play  [3];
  int m_disp  [3];
  int m_disph [3];
  int m_bcd   [3];
  int m_valid [3];
  int m_rem   [3];

  always #5 clk = ~clk;

  score_bcd #(.POINTS(617)) dut_a (
    .clk(clk), .rst(rst), .new_game(new_game), .eat(eat), .game_over(game_over),
    .frame(frame), .score(score_o[0]), .hiscore(hiscore_o[0]),
    .disp_score(disp_score_o[0]), .disp_hi(disp_hi_o[0]), .bcd(bcd_o[0]),
    .bcd_valid(bcd_valid_o[0]), .busy(busy_o[0])
  );

  score_bcd #(.POINTS(1000), .MAX_SCORE(4095)) dut_b (
    .clk(clk), .rst(rst), .new_game(new_game), .eat(eat), .game_over(game_over),
    .frame(frame), .score(score_o[1]), .hiscore(hiscore_o[1]),
    .disp_score(disp_score_o[1]), .disp_hi(disp_hi_o[1]), .bcd(bcd_o[1]),
    .bcd_valid(bcd_valid_o[1]), .busy(busy_o[1])
  );

  score_bcd dut_c (
    .clk(clk), .rst(rst), .new_game(new_game), .eat(eat), .game_over(game_over),
    .frame(frame), .score(score_o[2]), .hiscore(hiscore_o[2]),
    .disp_score(disp_score_o[2]), .disp_hi(disp_hi_o[2]), .bcd(bcd_o[2]),
    .bcd_valid(bcd_valid_o[2]), .busy(busy_o[2])
  );

  function automatic int to_bcd(input int v);
    return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10;
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_score[i] = 0; m_hi[i] = 0; m_play[i] = 0; m_disp[i] = 0;
      m_disph[i] = 0; m_bcd[i] = 0; m_valid[i] = 0; m_rem[i] = 0;
    end
  endtask

  // Conversion is modelled as a 13-edge countdown started by an accepted frame.
  task automatic model_step();
    if (!rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      int s = m_score[i];
      int h = m_hi[i];
      int p = m_play[i];
      if (m_rem[i] == 0) begin
        if (frame) begin
          m_disp[i] = s; m_disph[i] = h; m_rem[i] = 13; m_valid[i] = 0;
        end
      end else begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_bcd[i] = to_bcd(m_disp[i]);
          m_valid[i] = 1;
        end
      end
      if (new_game) begin
        m_score[i] = 0; m_play[i] = 1;
      end else if (p != 0 && game_over) begin
        m_hi[i] = (s > h) ? s : h;
        m_play[i] = 0;
      end else if (p != 0 && eat) begin
        m_score[i] = (s + pts[i] > 4095) ? 4095 : s + pts[i];
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("score[%0d]", i), score_o[i], m_score[i]);
      check_output($sformatf("hiscore[%0d]", i), hiscore_o[i], m_hi[i]);
      check_output($sformatf("disp_score[%0d]", i), disp_score_o[i], m_disp[i]);
      check_output($sformatf("disp_hi[%0d]", i), disp_hi_o[i], m_disph[i]);
      check_output($sformatf("bcd[%0d]", i), bcd_o[i], m_bcd[i]);
      check_output($sformatf("bcd_valid[%0d]", i), bcd_valid_o[i], m_valid[i]);
      check_output($sformatf("busy[%0d]", i), busy_o[i], (m_rem[i] > 0) ? 1 : 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic apply_stimulus(input logic ng, input logic ea, input logic go, input logic fr);
    new_game = ng; eat = ea; game_over = go; frame = fr;
    tick();
    new_game = 1'b0; eat = 1'b0; game_over = 1'b0; frame = 1'b0;
  endtask

  typedef struct {
    logic ng;
    logic ea;
    logic go;
    int   exp_score;
    int   exp_hi;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int edges;
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 0,    0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 0,    0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 617,  0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1234, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1234, 1234};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1234, 1234};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 0,    1234};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 617,  1234};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 617,  1234};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 617,  1234};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 0,    1234};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 617,  1234};

    model_reset();
    #3 rst = 1'b0;

    // Reset held with random inputs
    for (int k = 0; k < 5; k++) begin
      new_game = 1'($urandom); eat = 1'($urandom);
      game_over = 1'($urandom); frame = 1'($urandom);
      tick();
    end
    new_game = 1'b0; eat = 1'b0; game_over = 1'b0; frame = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_output("reset_score", score_o[i], 0);
      check_output("reset_bcd", bcd_o[i], 0);
      check_output("reset_busy", busy_o[i], 0);
    end
    rst = 1'b1;
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    edges = 0;
    while (bcd_valid_o[0] !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    check_output("reset_latency", edges, 13);
    check_output("reset_bcd_zero", bcd_o[0], 16'h0000);

    // Score keeping table on the POINTS=617 instance
    for (int v = 0; v < 12; v++) begin
      apply_stimulus(tbl[v].ng, tbl[v].ea, tbl[v].go, 1'b0);
      check_output($sformatf("tbl%0d_score", v), score_o[0], tbl[v].exp_score);
      check_output($sformatf("tbl%0d_hi", v), hiscore_o[0], tbl[v].exp_hi);
    end

    // Counting to 1234 then converting
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    check_output("count_score", score_o[0], 1234);
    check_output("count_disp", disp_score_o[0], 1234);
    for (int k = 1; k <= 13; k++) begin
      check_output($sformatf("count_busy_E%0d", k), busy_o[0], 1);
      tick();
    end
    check_output("count_busy_after", busy_o[0], 0);
    check_output("count_bcd", bcd_o[0], 16'h1234);
    check_output("count_valid", bcd_valid_o[0], 1);

    // Saturation on the POINTS=1000 instance
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    check_output("sat_score", score_o[1], 4095);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    check_output("sat_hold", score_o[1], 4095);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 13; k++) tick();
    check_output("sat_bcd", bcd_o[1], 16'h4095);

    // High score on the POINTS=1 instance
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    check_output("hi_first", hiscore_o[2], 7);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    check_output("eat_after_over", score_o[2], 7);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    check_output("hi_second", hiscore_o[2], 7);
    check_output("hi_second_score", score_o[2], 3);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check_output("newgame_eat", score_o[2], 0);

    // Second frame during conversion is ignored
    for (int k = 0; k < 5; k++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    check_output("ovl_disp_E0", disp_score_o[2], 5);
    for (int k = 1; k <= 13; k++) begin
      apply_stimulus(1'b0, (k == 2), 1'b0, (k == 5));
      if (k == 5) check_output("ovl_disp_E5", disp_score_o[2], 5);
    end
    check_output("ovl_bcd", bcd_o[2], 16'h0005);
    check_output("ovl_valid", bcd_valid_o[2], 1);
    tick();
    check_output("ovl_single_valid", bcd_valid_o[2], 1);
    check_output("ovl_single_busy", busy_o[2], 0);
    check_output("ovl_single_disp", disp_score_o[2], 5);

    // Reset in the middle of a conversion
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) tick();
    #2 rst = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      check_output("rstmid_busy", busy_o[i], 0);
      check_output("rstmid_valid", bcd_valid_o[i], 0);
      check_output("rstmid_bcd", bcd_o[i], 0);
    end
    tick();
    rst = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 13; k++) tick();
    check_output("rstmid_bcd_a", bcd_o[0], 16'h1851);
    check_output("rstmid_bcd_b", bcd_o[1], 16'h3000);
    check_output("rstmid_bcd_c", bcd_o[2], 16'h0003);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      new_game  = ($urandom_range(0, 39) == 0);
      eat       = ($urandom_range(0, 2) == 0);
      game_over = ($urandom_range(0, 29) == 0);
      frame     = ($urandom_range(0, 9) == 0);
      tick();
    end
    new_game = 1'b0; eat = 1'b0; game_over = 1'b0; frame = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
